// File: rtl/display_scan_driver_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan driver.
// Brightness width, digit-select sizing and the idle anode pattern live here.
package display_pkg;

    localparam int BRIGHT_W = 4;
    localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = 4'd15;
    localparam int ANODE_MAX = 64;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Pattern that leaves every anode dark: all ones for active-low boards.
    function automatic logic [ANODE_MAX-1:0] anode_off(input int n, input bit active_low);
        logic [ANODE_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < ANODE_MAX; i++) begin
            if (active_low && (i < n)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/display_scan_driver_slot_timer.sv
// Slot counter and digit index for the scan driver, with slot/frame strobes.
// Exposes next-cycle cnt/sel so the parent can register outputs aligned to them.
module slot_timer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    localparam int CNT_W      = $clog2(REFRESH_DIV),
    localparam int SEL_W      = sel_width(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_next,
    output logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] sel_next,
    output logic             slot_load,
    output logic             slot_strobe,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [SEL_W-1:0] sel_reg;
    logic             run_reg;
    logic             strobe_reg;
    logic             frame_reg;
    logic             wrap;

    always_comb begin
        wrap      = en && (cnt_reg == CNT_LAST);
        cnt_next  = '0;
        sel_next  = sel_reg;
        if (en && !wrap) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
        // Explicit wrap keeps non-power-of-two digit counts in range.
        if (wrap) begin
            sel_next = (sel_reg == SEL_LAST) ? '0 : sel_reg + SEL_W'(1);
        end
        // Inputs are captured at each slot start and on the first enabled edge
        // after reset or a pause (run_reg low).
        slot_load = en && (wrap || !run_reg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            sel_reg    <= '0;
            run_reg    <= 1'b0;
            strobe_reg <= 1'b0;
            frame_reg  <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            sel_reg    <= sel_next;
            run_reg    <= en;
            strobe_reg <= wrap;
            frame_reg  <= wrap && (sel_reg == SEL_LAST);
        end
    end

    assign sel         = sel_reg;
    assign slot_strobe = strobe_reg;
    assign frame_done  = frame_reg;

endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed seven-segment anode driver: self-timed digit slots with a blanking
// interval, per-digit enable mask and 4-bit PWM brightness, glitch-free anode register.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 500,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    localparam int SEL_W           = sel_width(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [SEL_W-1:0]      sel,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  slot_strobe,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        NUM_DIGITS'(anode_off(NUM_DIGITS, ANODE_ACTIVE_LOW));

    if (NUM_DIGITS < 2 || NUM_DIGITS > ANODE_MAX) begin : g_bad_num_digits
        $error("display_scan_driver: NUM_DIGITS must be in 2..%0d", ANODE_MAX);
    end
    if (REFRESH_DIV < 16) begin : g_bad_refresh_div
        $error("display_scan_driver: REFRESH_DIV must be >= 16");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank_cycles
        $error("display_scan_driver: BLANK_CYCLES must be in 0..REFRESH_DIV-1");
    end

    logic [CNT_W-1:0]      cnt_next;
    logic [SEL_W-1:0]      sel_next;
    logic                  slot_load;
    logic                  mask_reg, mask_next;
    logic [BRIGHT_W-1:0]   bright_reg, bright_next;
    logic [NUM_DIGITS-1:0] anode_reg, anode_next, drive_vec;
    scan_state_t           state_next;
    logic                  pixel_on;

    slot_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_slot_timer (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cnt_next    (cnt_next),
        .sel         (sel),
        .sel_next    (sel_next),
        .slot_load   (slot_load),
        .slot_strobe (slot_strobe),
        .frame_done  (frame_done)
    );

    always_comb begin
        mask_next   = mask_reg;
        bright_next = bright_reg;
        if (slot_load) begin
            mask_next   = digit_mask[sel_next];
            bright_next = brightness;
        end
    end

    // Everything is evaluated on next-cycle cnt/sel so the registered anode
    // matches the counter values visible in the same cycle.
    always_comb begin
        state_next = (cnt_next >= CNT_W'(BLANK_CYCLES)) ? DRIVE : BLANK;
        pixel_on   = 1'b0;
        if (en && (state_next == DRIVE) && mask_next) begin
            pixel_on = (bright_next == BRIGHT_FULL) ||
                       (cnt_next[BRIGHT_W-1:0] < bright_next);
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
        assign drive_vec[NUM_DIGITS-1-gi] = pixel_on && (sel_next == SEL_W'(gi));
    end

    assign anode_next = ANODE_OFF ^ drive_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_reg   <= 1'b0;
            bright_reg <= '0;
            anode_reg  <= ANODE_OFF;
        end else begin
            mask_reg   <= mask_next;
            bright_reg <= bright_next;
            anode_reg  <= anode_next;
        end
    end

    assign anode = anode_reg;

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Parametrised successor to the free-running anode driver for multiplexed seven-segment displays.
- Self-times digit slots from the system clock, supports N digits, and inserts a blanking interval at each digit change to suppress ghosting.
- Applies a per-digit enable mask and 4-bit PWM brightness.
- Sits between the system clock and the segment decoder. `sel` drives the digit-value mux; `anode` drives the board pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=2).
- REFRESH_DIV, 50000, clock cycles per digit slot (>=16).
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes inactive (< REFRESH_DIV).
- ANODE_ACTIVE_LOW, 1, 1 means an active digit is driven 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; 0 means all anodes inactive and scan frozen.
- digit_mask  in  NUM_DIGITS  bit i=1 enables digit i.
- brightness  in  4  PWM duty: 0 means off, 15 means full on.
- sel  out  SEL_W (clog2 NUM_DIGITS)  index of the current digit, for the value mux.
- anode  out  NUM_DIGITS  anode drives; digit i maps to anode[NUM_DIGITS-1-i].
- slot_strobe  out  1  one-cycle pulse in the first cycle of each new slot.
- frame_done  out  1  one-cycle pulse when sel wraps NUM_DIGITS-1 -> 0.

Behaviour:
- Reset (asynchronous, takes effect with no clock edge):
  - sel=0, cnt=0, anode all inactive (all 1s when active-low).
  - slot_strobe=0, frame_done=0.
  - Latched mask and brightness = 0.
- Slot counter `cnt` runs 0..REFRESH_DIV-1 while en=1.
  - At cnt==REFRESH_DIV-1, the next edge sets cnt=0 and sel=sel+1, wrapping NUM_DIGITS-1 -> 0.
  - slot_strobe=1 in the cycle where cnt==0 after an advance.
  - frame_done=1 in the same cycle, only when sel wrapped to 0.
  - No strobes at reset exit.
- Two-state FSM, state derived from cnt:
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE while cnt >= BLANK_CYCLES.
- digit_mask[sel_next] and brightness are latched on the edge that starts each slot, and on reset exit / en re-assert. Mid-slot input changes take effect at the next slot only.
- Anode drive:
  - All anodes are inactive in BLANK.
  - In DRIVE, anode[NUM_DIGITS-1-sel] is active iff latched_mask=1 AND (latched_bright==15 OR cnt[3:0] < latched_bright).
  - All other anodes are inactive.
- anode is a register whose value in any cycle is the function above of the cnt and sel present in that same cycle, so the output is glitch-free.
- Masked or brightness-0 digits still consume their full slot; scan timing is independent of content.
- en=0:
  - From the next edge, cnt is forced to 0, all anodes are inactive, and sel holds.
  - No strobes are produced.
  - On en re-assert, the current sel resumes from the start of its BLANK phase.
- Reset asserted mid-slot: all outputs go to their reset values immediately; the scan restarts at digit 0 after release.
- Width rules:
  - cnt width is clog2(REFRESH_DIV).
  - The sel increment wraps explicitly at NUM_DIGITS-1, which is correct for non-power-of-two NUM_DIGITS.
  - Out-of-range parameter values fail elaboration (assertion).

Decomposition:
- Package display_pkg holds:
  - BRIGHT_W=4 and BRIGHT_FULL=15.
  - A clog2-based sel-width function.
  - An anode_off(n, active_low) constant helper.
  - The scan_state_t enum {BLANK, DRIVE}.
- One natural sub-module, slot_timer:
  - Contains the cnt/sel counters and the strobe generation.
  - Outputs cnt, sel, slot_strobe, frame_done.
- The top level holds the input latches, PWM compare and anode register.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=32, BLANK_CYCLES=4, active-low.
- Reset/first slot: assert reset, then release with en=1, mask=4'hF, bright=15 -> anode=1111 and sel=0 during reset. After release, cnt 0-3 gives anode 1111 and cnt 4-31 gives 0111. Next cycle sel=1, slot_strobe=1, anode=1111 for 4 cycles, then 1011.
- Full frame: run 128 cycles -> drive order 0111, 1011, 1101, 1110. frame_done pulses exactly once, at sel 3->0. slot_strobe pulses 4 times.
- Mask: digit_mask=4'b1010 -> anode active only in slots sel=1 (1011) and sel=3 (1110). Slots 0 and 2 stay 1111 for the full 32 cycles.
- PWM: bright=4 -> per slot, anode active only at cnt 16-19 (4 cycles). bright=0 -> never active. bright changed at cnt=10 -> takes effect at the next slot only.
- Enable: deassert en at cnt=20 with sel=2 -> anode 1111 from the next edge, sel holds 2, no strobes. Re-assert -> 4 blank cycles, then 1101 from cnt=4.
- Async reset mid-DRIVE (sel=3, anode 1110): assert reset between clock edges -> anode=1111 and sel=0 before the next edge. After release, the scan restarts at digit 0.
